// File: rtl/calc_pkg.sv
// Shared definitions for the calculator's decimal-entry and display conversion paths.
package calc_pkg;

  localparam int unsigned BCD_DIGIT_W   = 4;
  localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;
  localparam int unsigned CALC_BIN_W    = 16;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StSign,
    StDone
  } conv_state_e;

endpackage

// File: rtl/bcd_digit_mac.sv
// One decimal accumulation step: acc*10 + digit, plus a flag for a non-decimal nibble.
module bcd_digit_mac
  import calc_pkg::*;
#(
  parameter int unsigned BIN_W = CALC_BIN_W
) (
  input  logic [BIN_W-1:0]       acc_i,
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BIN_W-1:0]       acc_o,
  output logic                   invalid_o
);

  always_comb begin
    acc_o     = (acc_i << 3) + (acc_i << 1) + BIN_W'(digit_i);
    invalid_o = (digit_i > BCD_MAX_DIGIT);
  end

endmodule

// File: rtl/bcd_to_bin.sv
// Packed BCD plus sign to two's-complement binary, one digit per cycle, MSD first,
// with valid/ready handshakes on input and output.
module bcd_to_bin
  import calc_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = CALC_BIN_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  input  logic                          neg_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BIN_W-1:0]              bin_out,
  output logic                          err
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  conv_state_e                   state_q, state_d;
  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_q, bcd_d;
  logic                          neg_q, neg_d;
  logic [BIN_W-1:0]              acc_q, acc_d;
  logic [IdxW-1:0]               idx_q, idx_d;
  logic                          err_flag_q, err_flag_d;
  logic [BIN_W-1:0]              bin_out_q, bin_out_d;
  logic                          err_q, err_d;
  logic                          out_valid_q, out_valid_d;

  logic [BCD_DIGIT_W-1:0] digit;
  logic [BIN_W-1:0]       mac_acc;
  logic                   mac_invalid;

  assign digit = bcd_q[int'(idx_q)*BCD_DIGIT_W +: BCD_DIGIT_W];

  bcd_digit_mac #(
    .BIN_W(BIN_W)
  ) u_mac (
    .acc_i    (acc_q),
    .digit_i  (digit),
    .acc_o    (mac_acc),
    .invalid_o(mac_invalid)
  );

  always_comb begin
    state_d     = state_q;
    bcd_d       = bcd_q;
    neg_d       = neg_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    err_flag_d  = err_flag_q;
    bin_out_d   = bin_out_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          bcd_d      = bcd_in;
          neg_d      = neg_in;
          acc_d      = '0;
          idx_d      = IdxW'(DIGITS - 1);
          err_flag_d = 1'b0;
          state_d    = StConv;
        end
      end
      StConv: begin
        // Keep accumulating past a bad digit; the result is zeroed in StSign anyway.
        acc_d      = mac_acc;
        err_flag_d = err_flag_q | mac_invalid;
        if (idx_q == '0) begin
          state_d = StSign;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      StSign: begin
        if (err_flag_q) begin
          bin_out_d = '0;
        end else if (neg_q) begin
          bin_out_d = '0 - acc_q;
        end else begin
          bin_out_d = acc_q;
        end
        err_d       = err_flag_q;
        out_valid_d = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bcd_q       <= '0;
      neg_q       <= 1'b0;
      acc_q       <= '0;
      idx_q       <= '0;
      err_flag_q  <= 1'b0;
      bin_out_q   <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      neg_q       <= neg_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      err_flag_q  <= err_flag_d;
      bin_out_q   <= bin_out_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign bin_out   = bin_out_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: vector table plus backpressure and mid-conversion reset cases.
module tb_bcd_to_bin;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] bcd_in = '0;
  logic        neg_in = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] bin_out;
  logic        err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] bcd;
    logic        neg;
    logic [15:0] exp_bin;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  bcd_to_bin #(
    .DIGITS(4),
    .BIN_W (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bcd_in   (bcd_in),
    .neg_in   (neg_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .bin_out  (bin_out),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Call at a negedge; returns at the negedge after the output handshake.
  task automatic wait_ready();
    for (int c = 0; c < 20; c++) begin
      if (in_ready) break;
      @(negedge clk);
    end
    chk("in_ready_before_op", 32'(in_ready), 32'd1);
  endtask

  task automatic accept(input logic [15:0] bcd, input logic neg);
    wait_ready();
    bcd_in   = bcd;
    neg_in   = neg;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    bcd_in   = 16'h5A5A;
    neg_in   = ~neg;
  endtask

  task automatic wait_out(input string name, output int lat);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    chk({name, "_latency"}, 32'(lat), 32'd5);
  endtask

  task automatic run_op(input string name, input vec_t v);
    int lat;
    accept(v.bcd, v.neg);
    wait_out(name, lat);
    chk({name, "_bin"}, 32'(bin_out), 32'(v.exp_bin));
    chk({name, "_err"}, 32'(err), 32'(v.exp_err));
    @(posedge clk);
    #1;
    chk({name, "_valid_pulse"}, 32'(out_valid), 32'd0);
    chk({name, "_ready_after"}, 32'(in_ready), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] held_bin;
    logic        held_err;
    int          lat;

    vecs[0] = '{16'h1234, 1'b0, 16'h04D2, 1'b0};
    vecs[1] = '{16'h9999, 1'b1, 16'hD8F1, 1'b0};
    vecs[2] = '{16'h0000, 1'b1, 16'h0000, 1'b0};
    vecs[3] = '{16'h12A4, 1'b0, 16'h0000, 1'b1};
    vecs[4] = '{16'h0042, 1'b0, 16'h002A, 1'b0};
    vecs[5] = '{16'h9999, 1'b0, 16'h270F, 1'b0};
    vecs[6] = '{16'h0001, 1'b1, 16'hFFFF, 1'b0};
    vecs[7] = '{16'h0500, 1'b0, 16'h01F4, 1'b0};
    vecs[8] = '{16'hF000, 1'b1, 16'h0000, 1'b1};
    vecs[9] = '{16'h1000, 1'b1, 16'hFC18, 1'b0};

    #12;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_bin_out", 32'(bin_out), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i]);
    end

    // Backpressure: result held, new operand ignored while waiting.
    out_ready = 1'b0;
    accept(16'h0321, 1'b0);
    wait_out("bp", lat);
    chk("bp_bin", 32'(bin_out), 32'h0141);
    held_bin = bin_out;
    held_err = err;
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        bcd_in   = 16'h5555;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      chk("bp_valid_held", 32'(out_valid), 32'd1);
      chk("bp_bin_stable", 32'(bin_out), 32'(held_bin));
      chk("bp_err_stable", 32'(err), 32'(held_err));
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_handshake_valid", 32'(out_valid), 32'd0);
    chk("bp_handshake_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("bp_no_ghost_op", 32'(out_valid), 32'd0);
    end

    // Reset in the second conversion cycle abandons the operand.
    accept(16'h8765, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_bin_out", 32'(bin_out), 32'd0);
    chk("rst_mid_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("rst_no_output", 32'(out_valid), 32'd0);
    end
    run_op("after_rst", '{16'h0007, 1'b0, 16'h0007, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin.md
Name: bcd_to_bin

Overview:
- Converts a 4-digit packed BCD magnitude plus a sign flag into a 16-bit two's-complement binary value. It is the inverse of the display-side binary-to-BCD path.
- Sits behind the keypad/decimal entry logic of the music calculator. It feeds entered operands (e.g. note frequencies or durations) into the binary arithmetic datapath.
- Iterative multiply-by-10-and-add, one digit per cycle, with a valid/ready handshake on both sides.

Parameters:
- DIGITS, 4, number of BCD digits in bcd_in (MSD in the top nibble).
- BIN_W, 16, width of the signed binary output. Must satisfy 10^DIGITS-1 < 2^(BIN_W-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  bcd_in/neg_in valid.
- in_ready  out  1  block can accept a new operand.
- bcd_in  in  4*DIGITS  packed BCD magnitude.
- neg_in  in  1  1 = negative value.
- out_valid  out  1  bin_out/err valid.
- out_ready  in  1  consumer accepts the result.
- bin_out  out  BIN_W  signed two's-complement result.
- err  out  1  an input nibble was > 9.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0, bin_out=0, err=0.
  - Internal accumulator, digit counter and latched operand are cleared.
  - Reset mid-conversion abandons the operation. No output is produced for it.
- States: IDLE, CONV, SIGN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch bcd_in and neg_in, acc=0, digit index=DIGITS-1, err_flag=0, go to CONV.
- CONV (DIGITS cycles, MSD first):
  - Each cycle: acc <= acc*10 + digit, computed as (acc<<3)+(acc<<1)+digit, all BIN_W bits wide.
  - If digit > 9, set err_flag. The accumulator update is still performed but its value is discarded later.
  - After digit index 0 is processed, go to SIGN.
- SIGN (1 cycle):
  - bin_out <= err_flag ? 0 : (neg ? -acc : acc).
  - err <= err_flag; out_valid <= 1; go to DONE.
- DONE:
  - out_valid, bin_out and err are held stable until out_ready=1.
  - On out_valid&out_ready: out_valid <= 0, go to IDLE. in_ready rises on the following cycle.
- Latency: out_valid is high DIGITS+1 cycles after the accepting edge, i.e. 5 cycles for the default parameters.
- Throughput: one operand per DIGITS+3 cycles with out_ready held high.
- in_ready is low in CONV, SIGN and DONE. in_valid in those states is ignored, and bcd_in changes have no effect after latching.
- Negative zero (neg_in=1, magnitude 0) gives bin_out=0.
- Maximum magnitude 9999 gives 16'h270F; -9999 gives 16'hD8F1. No overflow is possible under the BIN_W constraint.
- If out_ready is already high when out_valid rises, the handshake completes on that first DONE cycle.
- All outputs are registered. There is no combinational path from inputs to outputs, except that in_ready is decoded from the state register only.

Decomposition:
- Shared package `calc_pkg`:
  - State enum constants (IDLE/CONV/SIGN/DONE).
  - BCD_DIGIT_W=4, BCD_MAX_DIGIT=4'd9.
  - Default BIN_W, shared with the binary-to-BCD display path.
- One sub-module, `bcd_digit_mac`: combinational acc*10+digit, plus a digit-invalid flag, parameterised by BIN_W.
- The FSM, handshake and sign stage stay in bcd_to_bin.

Test Plan:
- Positive conversion: bcd_in=16'h1234, neg_in=0, out_ready=1.
  - bin_out=16'h04D2, err=0.
  - out_valid rises exactly 5 cycles after acceptance and stays high for 1 cycle.
- Negative full scale: bcd_in=16'h9999, neg_in=1 → bin_out=16'hD8F1.
- Negative zero: bcd_in=16'h0000, neg_in=1 → bin_out=16'h0000, err=0.
- Invalid digit: bcd_in=16'h12A4 → err=1, bin_out=16'h0000.
  - Next operand 16'h0042 → err=0, bin_out=16'h002A.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - bin_out and err stay stable and in_ready stays 0.
  - A new in_valid pulse with 16'h5555 during this time is ignored.
  - Raising out_ready gives one handshake, then in_ready=1 on the next cycle.
- Reset mid-operation: assert rst_n=0 during the 2nd CONV cycle of 16'h8765.
  - All outputs go to reset values immediately; no out_valid follows.
  - A subsequent 16'h0007 gives bin_out=16'h0007.
